// File: rtl/mdu_pkg.sv
// mult_div_unit shared types: op encodings, FSM states, op helpers.
// Divide support is enabled by defining MDU_DIV_EN.
package mdu_pkg;

  localparam logic [1:0] ENC_MULTU = 2'b00;
  localparam logic [1:0] ENC_MULT  = 2'b01;
  localparam logic [1:0] ENC_DIVU  = 2'b10;
  localparam logic [1:0] ENC_DIV   = 2'b11;

  typedef enum logic [1:0] {
    OP_MULTU = ENC_MULTU,
    OP_MULT  = ENC_MULT,
    OP_DIVU  = ENC_DIVU,
    OP_DIV   = ENC_DIV
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } mdu_state_t;

  function automatic logic op_signed(mdu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(mdu_op_t op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and mult_div_unit.
// The MDU sits on the slave side; the pipeline drives the master side.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    output hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    input  hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 step of the MDU engine over a {upper, lower} accumulator.
// Restoring divide step is compiled only when MDU_DIV_EN is defined.
module mdu_step #(
  parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
  input  logic               div_i,
`endif
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] mul;
`ifdef MDU_DIV_EN
  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] dv;
`endif

  always_comb begin
    sum = acc_i[2*WIDTH:WIDTH]
        + (acc_i[0] ? {1'b0, b_i} : '0);
    mul = {1'b0, sum, acc_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    sh   = {acc_i[2*WIDTH-1:0], 1'b0};
    diff = sh[2*WIDTH:WIDTH] - {1'b0, b_i};
    // borrow out means the trial subtract failed: keep shifted value
    dv   = diff[WIDTH] ? sh
         : {diff, sh[WIDTH-1:1], 1'b1};
    acc_o = div_i ? dv : mul;
`else
    acc_o = mul;
`endif
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// Define MDU_DIV_EN to build the divide datapath.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  mdu
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH:0] acc_q, acc_d, step_acc;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             dzo_q, dzo_d;
`ifdef MDU_DIV_EN
  logic             div_q, div_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo, rem;
`endif

  mdu_op_t          op_in;
  logic             sgn_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
    .div_i (div_q),
`endif
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (step_acc)
  );

  assign op_in  = mdu_op_t'(mdu.op);
  assign sgn_in = op_signed(op_in);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
`ifdef MDU_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    quo     = '0;
    rem     = '0;
`endif
    a_mag   = (sgn_in && mdu.src_a[WIDTH-1])
            ? -mdu.src_a : mdu.src_a;
    b_mag   = (sgn_in && mdu.src_b[WIDTH-1])
            ? -mdu.src_b : mdu.src_b;
    prod    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (mdu.hi_we) hi_d = mdu.wdata;
        if (mdu.lo_we) lo_d = mdu.wdata;
        if (mdu.start) begin
          acc_d = {{(WIDTH+1){1'b0}}, a_mag};
          b_d   = b_mag;
          cnt_d = CW'(WIDTH-1);
          neg_d = sgn_in
                & (mdu.src_a[WIDTH-1] ^ mdu.src_b[WIDTH-1]);
          dz_d  = 1'b0;
          state_d = S_CALC;
`ifdef MDU_DIV_EN
          div_d  = op_is_div(op_in);
          rneg_d = sgn_in & mdu.src_a[WIDTH-1];
          if (op_is_div(op_in) && (mdu.src_b == '0)) begin
            dz_d    = 1'b1;
            state_d = S_FIN;
          end
`else
          // without the divider, divide ops report as unsupported
          if (op_is_div(op_in)) begin
            dz_d    = 1'b1;
            state_d = S_FIN;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          dzo_d = 1'b1;
`ifdef MDU_DIV_EN
        end else if (div_q) begin
          quo  = acc_q[WIDTH-1:0];
          rem  = acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_q  ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
`endif
        end else begin
          prod = acc_q[2*WIDTH-1:0];
          if (neg_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
`ifdef MDU_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
`ifdef MDU_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign mdu.busy     = (state_q != S_IDLE);
  assign mdu.done     = done_q;
  assign mdu.div_zero = dzo_q;
  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: arithmetic reference model,
// directed corner cases followed by randomized operations.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, req, $time);
    end
  endtask

  // Reference: whole-value arithmetic on 64-bit integers.
  task automatic model(input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic wh, input logic wl,
                       input logic [W-1:0] wd, output exp_t e);
    logic [63:0] p;
    longint sa, sb2, qq, rr;
    logic [63:0] qv, rv;
    logic dz;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    dz = 1'b0;
    case (op)
      2'd0: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'd1: begin
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        p = 64'(sa * sb2);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b == '0) dz = 1'b1;
        else if (op == 2'd2) begin
          m_lo = a / b;
          m_hi = a % b;
        end else begin
          sa = longint'($signed(a));
          sb2 = longint'($signed(b));
          qq = sa / sb2;
          rr = sa % sb2;
          qv = 64'(qq);
          rv = 64'(rr);
          m_lo = qv[31:0];
          m_hi = rv[31:0];
        end
`else
        dz = 1'b1;
`endif
      end
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = dz;
    e.lat = dz ? 2 : W + 2;
    e.t0 = cyc;
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (t=%0t)",
                 $time);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(bus.hi), 64'(e.hi));
        chk("lo", 64'(bus.lo), 64'(e.lo));
        chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("busy_in_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic wh = 1'b0, input logic wl = 1'b0,
                        input logic [W-1:0] wd = '0,
                        input bit noise = 1'b0);
    exp_t e;
    bit got;
    bus.start = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.hi_we = wh;
    bus.lo_we = wl;
    bus.wdata = wd;
    model(op, a, b, wh, wl, wd, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    got = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_start", 64'(bus.busy), 64'd1);
      if (noise && i == 5) begin
        bus.start = 1'b1;
        bus.op = 2'(($urandom_range(0, 3)));
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000AAAA;
      end
      if (noise && i == 6) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected one (op=%0d)", op);
      sb.delete();
    end
  endtask

  task automatic mt(input bit to_hi, input logic [W-1:0] d);
    bus.hi_we = to_hi;
    bus.lo_we = !to_hi;
    bus.wdata = d;
    if (to_hi) m_hi = d;
    else m_lo = d;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    @(negedge clk);
    if (to_hi) chk("mthi", 64'(bus.hi), 64'(d));
    else chk("mtlo", 64'(bus.lo), 64'(d));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp [5];
    sp[0] = '0;
    sp[1] = 32'd1;
    sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'h80000000;
    sp[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);

    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, '0, 1'b1);
    run_op(2'd3, 32'hFFFFFFF9, 32'd2);
    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF);
    mt(1'b1, 32'h1234);
    mt(1'b0, 32'h5678);
    run_op(2'd2, 32'd100, 32'd0);
    run_op(2'd0, 32'd12345, 32'd678, 1'b0, 1'b0, '0, 1'b1);
    run_op(2'd0, 32'd3, 32'd4, 1'b1, 1'b1, 32'h0000BEEF);
    run_op(2'd2, 32'd5, 32'd0, 1'b1, 1'b1, 32'h0000BEEF);

    // Abort a multiply with reset ten cycles in.
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.src_a = 32'hDEADBEEF;
    bus.src_b = 32'h12345;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    repeat (40) @(negedge clk);
    run_op(2'd0, 32'd6, 32'd7);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic wh, wl;
      op = 2'($urandom_range(0, 3));
      wh = ($urandom_range(0, 7) == 0);
      wl = ($urandom_range(0, 7) == 0);
      run_op(op, pick(), pick(), wh, wl, $urandom,
             (op < 2) && ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
